// File: rtl/megaram_pkg.sv
// rtl/megaram_pkg.sv - shared types and constants for the megaram memory arbiter
package megaram_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  // Read data returned to the owner of an access that never got mem_ack
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_BUSY = 2'd1,
    ST_DMA_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/megaram_arb_timer.sv
// rtl/megaram_arb_timer.sv - grant timeout counter for the megaram arbiter
module megaram_arb_timer #(
  parameter int MEM_TIMEOUT = 63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expires on the edge that would bring the count to MEM_TIMEOUT
  assign expired_o = run_i && (cnt_q == CNT_LAST);

  // Count cycles with mem_req high; clear on every new grant, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/megaram_mem_arb.sv
// rtl/megaram_mem_arb.sv - CPU/DMA megaram arbiter; DMA port enabled by MEGARAM_DMA_PORT_EN
module megaram_mem_arb
  import megaram_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 8,
  parameter int MEM_TIMEOUT  = 63
) (
  input  logic              clk_27m,
  input  logic              bus_reset,
  input  logic              cpu_req,
  input  logic              cpu_wrt,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_wrt,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_req,
  output logic              mem_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int WAIT_W = (DMA_MAX_WAIT > 0) ? $clog2(DMA_MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_wrt_q, cpu_wrt_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
  logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wrt_q, mem_wrt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              timeout_err_q, timeout_err_d;

  logic dma_req_eff;
  logic dma_starved;
  logic cpu_cap;
  logic cpu_wins;
  logic cpu_hold;
  logic grant;
  logic tmr_expired;

`ifdef MEGARAM_DMA_PORT_EN
  assign dma_req_eff = dma_req;
`else
  logic dma_req_unused;
  assign dma_req_unused = dma_req;
  assign dma_req_eff    = 1'b0;
`endif

  // cpu_pend_q stays set until the CPU access completes, so it also covers "CPU owns an access"
  assign cpu_cap     = cpu_req && !cpu_pend_q;
  assign dma_starved = (dma_wait_q >= WAIT_MAX);
  assign cpu_wins    = cpu_pend_q && (!dma_req_eff || !dma_starved);
  // A CPU pulse being captured this cycle already outranks an unstarved DMA request
  assign cpu_hold    = cpu_cap && !dma_starved;

  megaram_arb_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_27m),
    .rst_i    (bus_reset),
    .clear_i  (grant),
    .run_i    (mem_req_q),
    .expired_o(tmr_expired)
  );

  // Next state: CPU capture, arbitration in IDLE, completion or abort in the BUSY states
  always_comb begin
    state_d       = state_q;
    cpu_pend_d    = cpu_pend_q;
    cpu_wrt_d     = cpu_wrt_q;
    cpu_addr_d    = cpu_addr_q;
    cpu_wdata_d   = cpu_wdata_q;
    dma_wait_d    = dma_wait_q;
    mem_req_d     = mem_req_q;
    mem_wrt_d     = mem_wrt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    timeout_err_d = timeout_err_q;
    cpu_ack_d     = 1'b0;
    dma_ack_d     = 1'b0;
    grant         = 1'b0;

    if (cpu_cap) begin
      cpu_pend_d  = 1'b1;
      cpu_wrt_d   = cpu_wrt;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_wins) begin
          state_d     = ST_CPU_BUSY;
          grant       = 1'b1;
          mem_req_d   = 1'b1;
          mem_wrt_d   = cpu_wrt_q;
          mem_addr_d  = cpu_addr_q;
          mem_wdata_d = cpu_wdata_q;
          if (dma_req_eff) begin
            dma_wait_d = dma_wait_q + 1'b1;
          end
        end else if (dma_req_eff && !cpu_hold) begin
          state_d     = ST_DMA_BUSY;
          grant       = 1'b1;
          mem_req_d   = 1'b1;
          mem_wrt_d   = dma_wrt;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          dma_wait_d  = '0;
        end
      end
      ST_CPU_BUSY: begin
        if (mem_ack || tmr_expired) begin
          state_d    = ST_IDLE;
          cpu_ack_d  = 1'b1;
          cpu_pend_d = 1'b0;
          mem_req_d  = 1'b0;
          mem_wrt_d  = 1'b0;
          if (mem_ack) begin
            if (!mem_wrt_q) begin
              cpu_rdata_d = mem_rdata;
            end
          end else begin
            cpu_rdata_d   = TIMEOUT_RDATA;
            timeout_err_d = 1'b1;
          end
        end
      end
      ST_DMA_BUSY: begin
        if (mem_ack || tmr_expired) begin
          state_d   = ST_IDLE;
          dma_ack_d = 1'b1;
          mem_req_d = 1'b0;
          mem_wrt_d = 1'b0;
          if (mem_ack) begin
            if (!mem_wrt_q) begin
              dma_rdata_d = mem_rdata;
            end
          end else begin
            dma_rdata_d   = TIMEOUT_RDATA;
            timeout_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access without an ack
  always_ff @(posedge clk_27m) begin
    if (bus_reset) begin
      state_q       <= ST_IDLE;
      cpu_pend_q    <= 1'b0;
      cpu_wrt_q     <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
      dma_wait_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_wrt_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      dma_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_pend_q    <= cpu_pend_d;
      cpu_wrt_q     <= cpu_wrt_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_wdata_q   <= cpu_wdata_d;
      dma_wait_q    <= dma_wait_d;
      mem_req_q     <= mem_req_d;
      mem_wrt_q     <= mem_wrt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      dma_ack_q     <= dma_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign dma_rdata   = dma_rdata_q;
  assign dma_ack     = dma_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_wrt     = mem_wrt_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/megaram_mem_arb.md
MEGARAM_MEM_ARB -- requirements
Module: megaram_mem_arb

Interface
REQ-001 Parameter DMA_MAX_WAIT, default 8: cycles a pending DMA request may lose to the CPU before it is forced ahead of the CPU.
REQ-002 Parameter MEM_TIMEOUT, default 63: cycles a granted access may wait for mem_ack before it is aborted.
REQ-003 clk_27m  in  1  sole clock; all logic on its rising edge.
REQ-004 bus_reset  in  1  reset, synchronous and active-high.
REQ-005 cpu_req  in  1  one-cycle pulse requesting a megaram access; cpu_wrt  in  1  write when high.
REQ-006 cpu_addr  in  21  megaram byte address; cpu_wdata  in  8  write data.
REQ-007 cpu_rdata  out  8  read data; cpu_ack  out  1  one-cycle completion pulse.
REQ-008 dma_req  in  1  level request, held until dma_ack; dma_wrt  in  1  write when high.
REQ-009 dma_addr  in  21  byte address; dma_wdata  in  8  write data.
REQ-010 dma_rdata  out  8  read data; dma_ack  out  1  one-cycle completion pulse.
REQ-011 mem_req  out  1  held high for the whole memory access; mem_wrt  out  1  write strobe.
REQ-012 mem_addr  out  21  address; mem_wdata  out  8  write data.
REQ-013 mem_rdata  in  8  read data; mem_ack  in  1  one-cycle completion pulse from memory.
REQ-014 timeout_err  out  1  sticky flag set by any aborted access.

Function
REQ-015 FSM states: IDLE, CPU_BUSY, DMA_BUSY.
REQ-016 A cpu_req pulse sets cpu_pend and latches cpu_wrt, cpu_addr and cpu_wdata when cpu_pend is clear and the CPU owns no access. Otherwise the pulse is dropped.
REQ-017 In IDLE, arbitration runs as follows:
  - cpu_pend with dma_wait < DMA_MAX_WAIT: go to CPU_BUSY.
  - dma_req: go to DMA_BUSY.
  - otherwise stay in IDLE.
REQ-018 dma_wait increments each cycle that dma_req is high in IDLE and the CPU wins. It clears on any DMA grant and saturates at DMA_MAX_WAIT.
REQ-019 On the transition into a BUSY state, mem_req rises the next cycle. mem_addr, mem_wrt and mem_wdata come from the granted port's latched or held values and stay stable until completion.
REQ-020 On mem_ack in CPU_BUSY:
  - cpu_rdata captures mem_rdata on reads.
  - cpu_ack pulses one cycle.
  - cpu_pend clears.
  - mem_req drops.
  - FSM returns to IDLE.
REQ-021 The DMA port completes the same way, using dma_rdata and dma_ack.
REQ-022 Minimum latency is 3 cycles from cpu_req to cpu_ack with zero memory wait: capture, grant, ack cycle.
REQ-023 A new grant occurs no earlier than one cycle after IDLE is re-entered. Back-to-back accesses are separated by one idle cycle.
REQ-024 A timeout counter clears at grant and counts while mem_req is high. On reaching MEM_TIMEOUT:
  - the access is aborted;
  - the owner's rdata becomes 8'hFF and its ack pulses;
  - timeout_err sets;
  - the FSM returns to IDLE.
REQ-025 mem_ack received in IDLE is ignored.
REQ-026 A cpu_req arriving in the same cycle as a DMA grant is captured and is served next.

Reset
REQ-027 bus_reset forces IDLE and clears cpu_pend, dma_wait, the timeout counter and timeout_err. An in-flight access is abandoned with no ack.
REQ-028 Reset values: mem_req, mem_wrt, cpu_ack and dma_ack = 0; mem_addr = 0; mem_wdata, cpu_rdata and dma_rdata = 8'h00.

Configuration
REQ-029 Macro MEGARAM_DMA_PORT_EN.
  - Defined: the DMA port and starvation logic behave as specified.
  - Undefined: dma_req is ignored, dma_ack = 0, dma_rdata = 8'h00, and DMA_BUSY is unreachable. Port list unchanged.

Structure
REQ-030 A shared package megaram_pkg holds:
  - the FSM state enum;
  - address width 21 and data width 8 constants;
  - the timeout read value 8'hFF.
REQ-031 One sub-module, megaram_arb_timer, implements the grant timeout counter. All other logic is flat.

Verification
REQ-032 CPU read at addr 21'h0A000, mem_ack 2 cycles after mem_req, mem_rdata 8'h5A -> cpu_ack once, cpu_rdata = 8'h5A, mem_addr = 21'h0A000 throughout.
REQ-033 cpu_req pulse and dma_req rise in the same cycle -> CPU granted first. DMA is granted one cycle after cpu_ack.
REQ-034 dma_req held while cpu_req pulses every 4 cycles -> DMA granted no later than after 8 CPU grants (DMA_MAX_WAIT = 8).
REQ-035 Granted DMA write with mem_ack never returned -> after 63 cycles dma_ack pulses, dma_rdata = 8'hFF, timeout_err = 1.
REQ-036 bus_reset asserted mid CPU_BUSY -> next cycle mem_req = 0, IDLE, no cpu_ack. A later cpu_req is served normally.
REQ-037 Build without MEGARAM_DMA_PORT_EN, dma_req held high -> mem_req never asserts for DMA, dma_ack stays 0.
